// File: rtl/ifmod_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encoding,
// word format and the default terminating instruction.
package ifmod_pkg;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] RECV  = 3'd1;
   localparam logic [2:0] WRITE = 3'd2;
   localparam logic [2:0] DONE  = 3'd3;
   localparam logic [2:0] CHECK = 3'd4;

   localparam int BYTES_PER_WORD = 4;

   localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

   // Number of words addressable with a byte address of the given width.
   function automatic int capacity_words(input int addr_width);
      return 1 << (addr_width - 2);
   endfunction

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// Shifts received bytes MSB-first into a word register and flags the byte
// that completes a word.
module byte_assembler
   import ifmod_pkg::*;
#(
   parameter int B = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         capture,
   input  logic [7:0]   rx_data,
   output logic [B-1:0] word,
   output logic         word_valid
);

   logic [B-1:0] word_reg;
   logic [1:0]   index_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_reg  <= '0;
         index_reg <= '0;
      end else if (clear) begin
         index_reg <= '0;
      end else if (capture) begin
         // Older bytes move up, so the first byte of a word ends in the top lane.
         word_reg  <= {word_reg[B-9:0], rx_data};
         index_reg <= index_reg + 2'd1;
      end
   end

   assign word       = word_reg;
   assign word_valid = capture && (index_reg == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Fills instruction memory from a received byte stream, one word per write
// stroke. Optional checksum byte after HALT: define INSTR_LOADER_CHECKSUM_EN.
module instr_mem_loader
   import ifmod_pkg::*;
#(
   parameter int            B         = 32,
   parameter int            W         = 5,
   parameter logic [B-1:0]  HALT_WORD = B'(DEFAULT_HALT_WORD)
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_start,
   input  logic [7:0]   i_rx_data,
   input  logic         i_rx_done,
   output logic         o_write,
   output logic [W-1:0] o_addr,
   output logic [B-1:0] o_data,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_full,
`ifdef INSTR_LOADER_CHECKSUM_EN
   output logic         o_cksum_err,
`endif
   output logic [W-2:0] o_word_count
);

   localparam int CAPACITY = capacity_words(W);

   logic [2:0]   state_reg, state_next;
   logic [W-1:0] addr_reg;
   logic [W-2:0] count_reg;
   logic         full_reg;

   logic         start_load;
   logic         is_halt;
   logic         at_capacity;
   logic         write_continue;
   logic         capture;
   logic         word_valid;
   logic [B-1:0] word;

`ifdef INSTR_LOADER_CHECKSUM_EN
   logic [7:0]   cksum_reg;
   logic         cksum_err_reg;
`endif

   assign start_load  = i_start && ((state_reg == IDLE) || (state_reg == DONE));
   assign is_halt     = (word == HALT_WORD);
   assign at_capacity = (count_reg == (W-1)'(CAPACITY - 1));

   // A strobe during WRITE belongs to the next word only if the load goes on.
   assign write_continue = (state_reg == WRITE) && !is_halt && !at_capacity;
   assign capture        = i_rx_done && ((state_reg == RECV) || write_continue);

   byte_assembler #(
      .B (B)
   ) u_assembler (
      .clk        (i_clk),
      .reset      (i_reset),
      .clear      (start_load),
      .capture    (capture),
      .rx_data    (i_rx_data),
      .word       (word),
      .word_valid (word_valid)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (i_start) state_next = RECV;
         end
         RECV: begin
            if (word_valid) state_next = WRITE;
         end
         WRITE: begin
            if (is_halt) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
               state_next = CHECK;
`else
               state_next = DONE;
`endif
            end else if (at_capacity) begin
               state_next = DONE;
            end else begin
               state_next = RECV;
            end
         end
`ifdef INSTR_LOADER_CHECKSUM_EN
         CHECK: begin
            if (i_rx_done) state_next = DONE;
         end
`endif
         DONE: begin
            if (i_start) state_next = RECV;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         count_reg <= '0;
         full_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (start_load) begin
            addr_reg  <= '0;
            count_reg <= '0;
            full_reg  <= 1'b0;
         end else if (state_reg == WRITE) begin
            count_reg <= count_reg + 1'b1;
            if (write_continue) addr_reg <= addr_reg + W'(BYTES_PER_WORD);
            if (!is_halt && at_capacity) full_reg <= 1'b1;
         end
      end
   end

`ifdef INSTR_LOADER_CHECKSUM_EN
   // Running XOR covers every byte that went into a word, HALT bytes included.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cksum_reg     <= '0;
         cksum_err_reg <= 1'b0;
      end else if (start_load) begin
         cksum_reg     <= '0;
         cksum_err_reg <= 1'b0;
      end else begin
         if (capture) cksum_reg <= cksum_reg ^ i_rx_data;
         if ((state_reg == CHECK) && i_rx_done) cksum_err_reg <= (i_rx_data != cksum_reg);
      end
   end

   assign o_cksum_err = cksum_err_reg;
`endif

   assign o_write      = (state_reg == WRITE);
   assign o_addr       = addr_reg;
   assign o_data       = word;
`ifdef INSTR_LOADER_CHECKSUM_EN
   assign o_busy       = (state_reg == RECV) || (state_reg == WRITE) || (state_reg == CHECK);
`else
   assign o_busy       = (state_reg == RECV) || (state_reg == WRITE);
`endif
   assign o_done       = (state_reg == DONE);
   assign o_full       = full_reg;
   assign o_word_count = count_reg;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed and randomized loads checked against a word-list reference model.
module tb_instr_mem_loader;

   localparam int          W    = 5;
   localparam int          CAP  = 8;
   localparam logic [31:0] HALT = 32'hFFFF_FFFF;

   logic         i_clk = 1'b0;
   logic         i_reset;
   logic         i_start;
   logic [7:0]   i_rx_data;
   logic         i_rx_done;
   logic         o_write;
   logic [W-1:0] o_addr;
   logic [31:0]  o_data;
   logic         o_busy;
   logic         o_done;
   logic         o_full;
   logic [W-2:0] o_word_count;
`ifdef INSTR_LOADER_CHECKSUM_EN
   logic         o_cksum_err;
`endif

   int total = 0;
   int bad   = 0;

   logic [W-1:0] wr_addr_q[$];
   logic [31:0]  wr_data_q[$];
   logic [31:0]  stim_q[$];

   instr_mem_loader #(.B(32), .W(W), .HALT_WORD(HALT)) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_rx_data    (i_rx_data),
      .i_rx_done    (i_rx_done),
      .o_write      (o_write),
      .o_addr       (o_addr),
      .o_data       (o_data),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_full       (o_full),
`ifdef INSTR_LOADER_CHECKSUM_EN
      .o_cksum_err  (o_cksum_err),
`endif
      .o_word_count (o_word_count)
   );

   always #5 i_clk = ~i_clk;

   // Write strokes last one full cycle, so each is seen at exactly one falling edge.
   always @(negedge i_clk) begin
      if (o_write === 1'b1) begin
         wr_addr_q.push_back(o_addr);
         wr_data_q.push_back(o_data);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge i_clk);
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      @(negedge i_clk);
      i_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      i_rx_data = b;
      i_rx_done = 1'b1;
      @(negedge i_clk);
      i_rx_done = 1'b0;
      i_rx_data = $urandom_range(0, 255);
      repeat (gap) @(negedge i_clk);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (o_done !== 1'b1 && n < 200) begin
         @(negedge i_clk);
         n++;
      end
      chk(tag, {31'd0, o_done}, 32'd1);
   endtask

   // Model: words are written at 0,4,8,... until HALT (written) or capacity.
   task automatic run_load(input string tag, input int gap_max, input bit start_mid, input bit bad_ck);
      logic [W-1:0] e_addr[$];
      logic [31:0]  e_data[$];
      logic [7:0]   cks;
      logic [7:0]   b;
      int           n;
      int           cnt_before;
      bit           e_full;
      bit           halted;
      n = 0; e_full = 1'b0; halted = 1'b0; cks = 8'h00;
      for (int i = 0; i < stim_q.size(); i++) begin
         if (halted || e_full) break;
         e_addr.push_back(W'(4 * i));
         e_data.push_back(stim_q[i]);
         n++;
         cks = cks ^ stim_q[i][31:24] ^ stim_q[i][23:16] ^ stim_q[i][15:8] ^ stim_q[i][7:0];
         if (stim_q[i] == HALT) halted = 1'b1;
         else if (n == CAP) e_full = 1'b1;
      end

      wr_addr_q.delete();
      wr_data_q.delete();
      pulse_start();
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = stim_q[i][31 - 8 * k -: 8];
            send_byte(b, $urandom_range(0, gap_max));
            if (start_mid && i == 0 && k == 0) pulse_start();
         end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (halted) begin
         cyc(2);
         send_byte(bad_ck ? 8'h00 : cks, 0);
      end
`endif
      wait_done({tag, ".done"});
      chk({tag, ".nwr"}, wr_addr_q.size(), e_addr.size());
      for (int i = 0; i < e_addr.size() && i < wr_addr_q.size(); i++) begin
         chk($sformatf("%s.addr%0d", tag, i), wr_addr_q[i], e_addr[i]);
         chk($sformatf("%s.data%0d", tag, i), wr_data_q[i], e_data[i]);
      end
      chk({tag, ".count"}, o_word_count, n);
      chk({tag, ".full"}, o_full, e_full);
      chk({tag, ".busy"}, o_busy, 0);
`ifdef INSTR_LOADER_CHECKSUM_EN
      chk({tag, ".ckerr"}, o_cksum_err, (halted && bad_ck) ? (cks != 8'h00) : 1'b0);
`endif
      // Bytes arriving in DONE must not start a new word.
      cnt_before = wr_addr_q.size();
      send_byte(8'h11, 0);
      send_byte(8'h22, 1);
      chk({tag, ".ign_wr"}, wr_addr_q.size(), cnt_before);
      chk({tag, ".ign_cnt"}, o_word_count, n);
      chk({tag, ".ign_done"}, o_done, 1);
      $display("load %s: words=%0d full=%0d halt=%0d", tag, n, e_full, halted);
   endtask

   initial begin
      i_reset   = 1'b1;
      i_start   = 1'b0;
      i_rx_done = 1'b0;
      i_rx_data = 8'h00;
      cyc(2);
      chk("rst.write", o_write, 0);
      chk("rst.addr",  o_addr, 0);
      chk("rst.data",  o_data, 0);
      chk("rst.busy",  o_busy, 0);
      chk("rst.done",  o_done, 0);
      chk("rst.full",  o_full, 0);
      chk("rst.count", o_word_count, 0);
      i_reset = 1'b0;
      cyc(1);

      // Bytes in IDLE are ignored.
      wr_addr_q.delete();
      for (int i = 0; i < 4; i++) send_byte(8'(8'hA0 + i), 0);
      cyc(2);
      chk("idle.nwr",  wr_addr_q.size(), 0);
      chk("idle.busy", o_busy, 0);
      chk("idle.data", o_data, 0);

      // Asynchronous reset in the middle of a word.
      pulse_start();
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      chk("mid.busy", o_busy, 1);
      #2 i_reset = 1'b1;
      #1;
      chk("arst.busy",  o_busy, 0);
      chk("arst.data",  o_data, 0);
      chk("arst.done",  o_done, 0);
      chk("arst.count", o_word_count, 0);
      @(negedge i_clk);
      i_reset = 1'b0;
      cyc(1);

      stim_q = '{32'h1234_5678, HALT};
      run_load("after_rst", 1, 1'b0, 1'b0);

      stim_q = '{32'h2001_0005, HALT};
      run_load("basic", 1, 1'b0, 1'b0);

      stim_q.delete();
      for (int i = 0; i < 10; i++) stim_q.push_back({8'(i + 1), 8'h5A, 8'hC3, 8'(i * 7)});
      run_load("capacity", 2, 1'b0, 1'b0);

      stim_q = '{32'h0102_0304, 32'h0506_0708, HALT};
      run_load("b2b", 0, 1'b0, 1'b0);

      stim_q = '{32'hDEAD_BEEF, 32'hFFFF_FF00, HALT};
      run_load("start_busy", 1, 1'b1, 1'b0);

      stim_q = '{32'h2001_0005, HALT};
      run_load("ck_bad", 1, 1'b0, 1'b1);

      for (int r = 0; r < 8; r++) begin
         stim_q.delete();
         for (int i = 0; i < $urandom_range(1, 11); i++)
            stim_q.push_back(($urandom_range(0, 6) == 0) ? HALT : 32'($urandom));
         if (stim_q[stim_q.size() - 1] != HALT && stim_q.size() < CAP) stim_q.push_back(HALT);
         run_load($sformatf("rand%0d", r), 2, 1'(r % 3 == 0), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Sequencer that fills the instruction memory from a byte stream delivered by the debug/UART receiver.
- Assembles 4 bytes into one 32-bit instruction, MSB first.
- Issues one-cycle write strokes at word-aligned byte addresses 0, 4, 8, …
- Stops on a HALT word or when memory is full, then reports done so the pipeline can be released from reset/stall.

Parameters:
- B, 32, instruction width in bits (fixed at 32; four bytes per word).
- W, 5, instruction-memory address width in bits; byte addressing, capacity 2**(W-2) words.
- HALT_WORD, 32'hFFFF_FFFF, instruction value that ends a load; it is written to memory before stopping.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous reset, active-high; all state cleared immediately.
- i_start  in  1  one-cycle pulse; begins a load from IDLE or DONE.
- i_rx_data  in  8  received byte.
- i_rx_done  in  1  one-cycle strobe; i_rx_data is valid this cycle.
- o_write  out  1  memory write enable, one cycle per word.
- o_addr  out  W  memory byte address, word-aligned (low 2 bits always 0).
- o_data  out  B  assembled instruction to write.
- o_busy  out  1  high in RECV and WRITE.
- o_done  out  1  high in DONE, held until i_start or reset.
- o_full  out  1  high in DONE when the load ended on capacity rather than HALT_WORD.
- o_word_count  out  W-1  number of words written in the current/last load.

Behaviour:
- Reset (async, active-high): state=IDLE; o_write=0, o_addr=0, o_data=0, o_busy=0, o_done=0, o_full=0, o_word_count=0; byte index=0. Reset mid-load aborts with no further writes. Memory contents are untouched.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: on i_start, go to RECV; clear address, byte index, word count, o_full. Bytes arriving in IDLE are ignored.
- RECV: on each i_rx_done, shift the byte into the data register (first byte → bits 31:24, fourth → 7:0) and increment the byte index (2-bit, wraps).
  - When the 4th byte is captured: go to WRITE next cycle.
  - o_data holds the full word.
- WRITE (exactly one cycle): o_write=1 with o_addr and o_data stable this cycle; word count increments at the end of the cycle. Then:
  - if o_data==HALT_WORD → DONE, o_full=0;
  - else if word count reaches 2**(W-2) → DONE, o_full=1;
  - else o_addr += 4 → RECV.
- Write latency: the write strobe asserts the cycle after the 4th i_rx_done.
- A byte strobe in the WRITE cycle is captured as byte 0 of the next word, so back-to-back strobes are never lost.
- DONE: o_done=1, o_write=0. Bytes are ignored. i_start restarts the load as from IDLE (address 0).
- i_start while busy is ignored.
- Address arithmetic: o_addr is an unsigned W-bit value and never wraps; capacity stops the load first.
- o_addr updates only after the WRITE cycle.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- Enabled:
  - After HALT_WORD is written, FSM enters an extra CHECK state and waits for one more byte.
  - That byte is compared with the XOR of all received bytes, HALT bytes included.
  - Extra output o_cksum_err (1 bit, reset 0) is set on mismatch; DONE is entered either way.
  - A capacity stop skips CHECK.
- Disabled: no CHECK state, no o_cksum_err port; HALT goes directly to DONE.

Decomposition:
- Shared package ifmod_pkg holds: FSM state encoding (localparams IDLE/RECV/WRITE/DONE/CHECK), BYTES_PER_WORD=4, default HALT_WORD.
- One natural sub-module: byte_assembler (shift register plus 2-bit byte index, outputs word_valid). The FSM, address counter and word counter stay in the top.

Test Plan:
- Reset defaults: assert reset mid-RECV after 2 bytes → all outputs 0 immediately; then i_start plus 4 bytes → first write lands at address 0, not at a stale address.
- Basic load: i_start; bytes 20 01 00 05, then FF FF FF FF → writes 32'h2001_0005 @0, then 32'hFFFF_FFFF @4; o_done=1, o_full=0, o_word_count=2.
- Capacity (W=5): 8 non-HALT words → last write @28, o_full=1, o_done=1, no write @32.
- Back-to-back strobes: i_rx_done on consecutive cycles, including the WRITE cycle → no byte lost; words 32'h0102_0304 @0 and 32'h0506_0708 @4.
- Ignored inputs: i_start while busy, and bytes in IDLE/DONE → no writes, counters unchanged; i_start in DONE restarts at address 0.
- Checksum (with INSTR_LOADER_CHECKSUM_EN): load 20 01 00 05 FF FF FF FF, then byte 24 → o_cksum_err=0; repeat with byte 00 → o_cksum_err=1.
